// File: rtl/layer_result_pingpong_mem.sv
`default_nettype none
// ============================================================================
// Module   : layer_result_pingpong_mem
// Purpose  : Double-buffered (ping-pong) result store. A writer fills one bank
//            while a reader consumes the other. Each bank holds MAP_W*MAP_H
//            words of DATA_W bits, and the linear index is row*MAP_W+col.
// Ports    : clk, rst (sync, active-high)
//            save_enable/save_row_addr/save_col_addr/save_data_in - write port
//            save_frame_done - writer hands the current bank over
//            save_ready      - the write bank is free
//            read_signal/read_row_addr/read_col_addr - read port (1-cycle latency)
//            read_frame_done - reader releases the current bank
//            read_ready      - a completed bank is readable
//            result_output/result_valid - registered read data and its qualifier
//            addr_error      - sticky out-of-range flag
// Options  : RESULT_MEM_BOUNDS_CHECK_EN - enables row/col range checking.
// Revision : 1.0 - initial release
// ============================================================================
module layer_result_pingpong_mem #(
  parameter int DATA_W = 128,
  parameter int MAP_W  = 14,
  parameter int MAP_H  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_enable,
  input  logic [15:0]       save_row_addr,
  input  logic [15:0]       save_col_addr,
  input  logic [DATA_W-1:0] save_data_in,
  input  logic              save_frame_done,
  output logic              save_ready,
  input  logic              read_signal,
  input  logic [15:0]       read_row_addr,
  input  logic [15:0]       read_col_addr,
  input  logic              read_frame_done,
  output logic              read_ready,
  output logic [DATA_W-1:0] result_output,
  output logic              result_valid,
  output logic              addr_error
);

  localparam int DEPTH = MAP_W * MAP_H;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is deliberately not reset.
  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [DATA_W-1:0] result_output_q;
  logic              result_valid_q;

  // Full-width linear index so the product never wraps before any check.
  logic [32:0]       w_wr_lin, w_rd_lin;
  logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
  logic              w_wr_in_range, w_rd_in_range;
  logic              w_wr_acc, w_rd_acc;
  logic              w_sfd_acc, w_rfd_acc;

  assign save_ready = ~full_q[wr_bank_q];
  assign read_ready = full_q[rd_bank_q];

  assign w_wr_lin = 33'(save_row_addr) * 33'(MAP_W) + 33'(save_col_addr);
  assign w_rd_lin = 33'(read_row_addr) * 33'(MAP_W) + 33'(read_col_addr);
  assign w_wr_idx = w_wr_lin[IDX_W-1:0];
  assign w_rd_idx = w_rd_lin[IDX_W-1:0];

`ifdef RESULT_MEM_BOUNDS_CHECK_EN
  logic addr_error_q;

  assign w_wr_in_range = (save_row_addr < 16'(MAP_H)) && (save_col_addr < 16'(MAP_W));
  assign w_rd_in_range = (read_row_addr < 16'(MAP_H)) && (read_col_addr < 16'(MAP_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_error_q <= 1'b0;
    end else if ((save_enable && save_ready && !w_wr_in_range) ||
                 (w_rd_acc && !w_rd_in_range)) begin
      addr_error_q <= 1'b1;
    end
  end

  assign addr_error = addr_error_q;
`else
  assign w_wr_in_range = 1'b1;
  assign w_rd_in_range = 1'b1;
  assign addr_error    = 1'b0;
`endif

  // Reset gates the write so a strobe coincident with rst never lands.
  assign w_wr_acc  = ~rst & save_enable & save_ready & w_wr_in_range;
  assign w_rd_acc  = read_signal & read_ready;
  assign w_sfd_acc = save_frame_done & save_ready;
  assign w_rfd_acc = read_frame_done & read_ready;

  // The two frame-done events always hit different banks (a bank cannot be
  // both free and full), so both updates can be applied in the same cycle.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (w_sfd_acc) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (w_rfd_acc) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      full_q          <= 2'b00;
      result_output_q <= '0;
      result_valid_q  <= 1'b0;
    end else begin
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      full_q         <= full_d;
      result_valid_q <= w_rd_acc;
      if (w_rd_acc) begin
        // Out-of-range reads (only reachable with checking on) return zero.
        result_output_q <= w_rd_in_range ? mem_q[rd_bank_q][w_rd_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem_q[wr_bank_q][w_wr_idx] <= save_data_in;
    end
  end

  assign result_output = result_output_q;
  assign result_valid  = result_valid_q;

endmodule
`default_nettype wire

// File: doc/layer_result_pingpong_mem.md
LAYER_RESULT_PINGPONG_MEM -- requirements
Module: layer_result_pingpong_mem

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set the result word width in bits.
REQ-002 Parameter MAP_W, default 14, SHALL set the feature-map columns per frame.
REQ-003 Parameter MAP_H, default 14, SHALL set the feature-map rows per frame.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- save_enable  input  1  write strobe.
- save_row_addr  input  16  write row.
- save_col_addr  input  16  write column.
- save_data_in  input  DATA_W  write data.
- save_frame_done  input  1  single-cycle pulse: writer finished the current frame.
- save_ready  output  1  the write bank is free.
- read_signal  input  1  read strobe.
- read_row_addr  input  16  read row.
- read_col_addr  input  16  read column.
- read_frame_done  input  1  single-cycle pulse: reader releases the current frame.
- read_ready  output  1  a completed frame is readable.
- result_output  output  DATA_W  registered read data.
- result_valid  output  1  result_output holds data from a read issued the previous cycle.
- addr_error  output  1  sticky out-of-range access flag.

Function
REQ-005 Storage SHALL be two banks, each holding MAP_W*MAP_H words of DATA_W bits; the linear index SHALL be row*MAP_W+col.
REQ-006 State SHALL consist of: wr_bank (1 bit), rd_bank (1 bit) and full[1:0].
- save_ready = ~full[wr_bank].
- read_ready = full[rd_bank].
REQ-007 A write SHALL occur at the clock edge when save_enable=1 and save_ready=1 and the address is in range; any other write SHALL be dropped.
REQ-008 When save_frame_done=1 and save_ready=1, the block SHALL set full[wr_bank] and toggle wr_bank. A write in the same cycle SHALL land in the old bank. When save_ready=0, the pulse SHALL be ignored.
REQ-009 When read_signal=1 and read_ready=1, the next cycle SHALL show:
- result_valid=1;
- result_output = bank[rd_bank][index], with read latency exactly 1 cycle.
REQ-010 When read_signal=0 or read_ready=0, the next cycle SHALL show result_valid=0, and result_output SHALL hold its previous value.
REQ-011 When read_frame_done=1 and read_ready=1, the block SHALL clear full[rd_bank] and toggle rd_bank. A read in the same cycle SHALL use the old bank. When read_ready=0, the pulse SHALL be ignored.
REQ-012 A write-side event and a read-side event in the same cycle SHALL both take effect. By construction they target different banks: when wr_bank==rd_bank, save_ready and read_ready are mutually exclusive.
REQ-013 When both banks are full, save_ready=0 SHALL hold until a read_frame_done is accepted; save_ready SHALL then be 1 in the following cycle.
REQ-014 There SHALL be no write-to-read bypass: a bank becomes readable only after its save_frame_done.
REQ-015 Address computation SHALL use full 16-bit row/col values; no truncation SHALL occur before the range check.

Reset
REQ-016 While rst=1 at a clock edge, the block SHALL set:
- wr_bank=0, rd_bank=0, full=2'b00;
- result_output=0, result_valid=0, addr_error=0.
REQ-017 After reset, save_ready=1 and read_ready=0 SHALL hold.
REQ-018 Memory contents SHALL NOT be reset.
REQ-019 Reset SHALL take priority over all strobes in the same cycle and SHALL abandon any partially written or partially read frame.

Configuration
REQ-020 Macro RESULT_MEM_BOUNDS_CHECK_EN, when defined, SHALL enable range checking (row<MAP_H and col<MAP_W).
- Out-of-range write: dropped; addr_error set.
- Out-of-range accepted read: result_valid=1, result_output=0; addr_error set.
- addr_error SHALL clear only on reset.
REQ-021 Without RESULT_MEM_BOUNDS_CHECK_EN, addr_error SHALL be constant 0 and no range logic SHALL exist. Out-of-range accesses are then prohibited by the caller, and their effect is unspecified.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then write (row 3, col 5, data 128'hA5) and pulse save_frame_done. Then read_ready=1; reading (3,5) gives result_output=128'hA5 and result_valid=1 exactly one cycle later.
- Fill bank0 and bank1 with save_frame_done each, no reads. save_ready=0, and a third write of 128'h77 to (0,0) is dropped, so bank0 (0,0) still returns the original data.
- Both banks full; read_frame_done and a write to (1,1) are applied in the same cycle. save_ready=1 the next cycle; the write issued then lands in bank0 (the bank just released), and bank1 remains readable.
- Read issued with read_ready=0. result_valid=0 the next cycle, and result_output holds its prior value.
- With RESULT_MEM_BOUNDS_CHECK_EN defined, write (14,0) and read (0,14) with MAP_W=MAP_H=14. The write is dropped, the read returns 0 with result_valid=1, and addr_error=1 persists until rst.
- rst asserted mid-frame after 10 writes. Then save_ready=1, read_ready=0, result_valid=0 and addr_error=0, and the bench confirms wr_bank=0.
